// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      D_WAIT  = 2'd1,
      I_WAIT  = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [3:0]  BE_WORD       = 4'hF;

endpackage

// File: rtl/unified_mem_arbiter_mem_timeout_ctr.sv
// Down-counter that flags when a memory transfer has waited its full budget.
module mem_timeout_ctr #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Loaded with TIMEOUT-1 on entry, so reaching zero marks the last allowed wait cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = LOAD;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store, freezing the
// pipeline until the data access (if any) and then the fetch (if any) complete.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int          TIMEOUT   = 64,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ireq,
   input  logic [31:0] iaddr,
   input  logic        dreq,
   input  logic        dwe,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dbe,
   output logic [31:0] instr_o,
   output logic [31:0] drdata_o,
   output logic        stall_o,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_err
);

   arb_state_e  state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] drdata_q, drdata_d;
   logic        mem_err_q, mem_err_d;
   logic        ctr_clr, ctr_en, ctr_expired;

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (ctr_clr),
      .en      (ctr_en),
      .expired (ctr_expired)
   );

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      drdata_d  = drdata_q;
      mem_err_d = mem_err_q;
      stall_o   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      ctr_en    = 1'b0;

      case (state_q)
         IDLE: begin
            stall_o = dreq | ireq;
            if (dreq) begin
               state_d = D_WAIT;
            end else if (ireq) begin
               state_d = I_WAIT;
            end
         end
         D_WAIT: begin
            stall_o   = 1'b1;
            mem_req   = 1'b1;
            mem_we    = dwe;
            mem_addr  = daddr;
            mem_wdata = dwdata;
            mem_be    = dbe;
            ctr_en    = ~mem_ack;
            // An ack on the final budget cycle still wins over the abort.
            if (mem_ack || ctr_expired) begin
               if (!dwe) begin
                  drdata_d = mem_ack ? mem_rdata : '0;
               end
               if (!mem_ack) begin
                  mem_err_d = 1'b1;
               end
               state_d = ireq ? I_WAIT : RELEASE;
            end
         end
         I_WAIT: begin
            stall_o  = 1'b1;
            mem_req  = 1'b1;
            mem_addr = iaddr;
            mem_be   = BE_WORD;
            ctr_en   = ~mem_ack;
            if (mem_ack || ctr_expired) begin
               instr_d = mem_ack ? mem_rdata : NOP_INSTR;
               if (!mem_ack) begin
                  mem_err_d = 1'b1;
               end
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Restart the wait budget whenever a new transfer begins, including D_WAIT -> I_WAIT.
      ctr_clr = ((state_d == D_WAIT) || (state_d == I_WAIT)) && (state_d != state_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         instr_q   <= '0;
         drdata_q  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         drdata_q  <= drdata_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign instr_o  = instr_q;
   assign drdata_o = drdata_q;
   assign mem_err  = mem_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised scoreboard bench for unified_mem_arbiter with a reactive memory model.
module tb_unified_mem_arbiter;

   localparam int          TO  = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0;
   logic [31:0] iaddr = '0, daddr = '0, dwdata = '0;
   logic [3:0]  dbe = '0;
   logic [31:0] instr_o, drdata_o, mem_addr, mem_wdata;
   logic        stall_o, mem_req, mem_we, mem_err;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          chk_wdata;
      int          delay;
      logic [31:0] rdata;
   } xfer_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] drdata;
      logic        err;
      int          stalls;
   } rel_t;

   xfer_t xfer_q[$];
   rel_t  rel_q[$];

   logic [31:0] m_instr = '0, m_drdata = '0;
   logic        m_err = 1'b0;

   unified_mem_arbiter #(.TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .ireq(ireq), .iaddr(iaddr), .dreq(dreq), .dwe(dwe),
      .daddr(daddr), .dwdata(dwdata), .dbe(dbe), .instr_o(instr_o), .drdata_o(drdata_o),
      .stall_o(stall_o), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Cycles a transfer occupies: ack index + 1, capped by the abort at TO-1.
   function automatic int xlen(input int d);
      return ((d < TO) ? d : TO - 1) + 1;
   endfunction

   function automatic int pick_delay();
      case ($urandom_range(0, 7))
         0, 4:    return 0;
         1, 7:    return 1;
         2:       return 2;
         3:       return 3;
         5:       return TO - 1;
         default: return TO + 3;
      endcase
   endfunction

   task automatic issue(input bit dr, input bit we, input logic [31:0] da, input logic [31:0] wd,
                        input logic [3:0] be, input bit ir, input logic [31:0] ia,
                        input int dd, input logic [31:0] drd, input int id, input logic [31:0] ird);
      rel_t r;
      int   stalls = 1;
      bit   done = 0;
      if (dr) begin
         xfer_q.push_back('{addr: da, we: we, wdata: wd, be: be, chk_wdata: 1'b1, delay: dd, rdata: drd});
         stalls += xlen(dd);
         if (!we) m_drdata = (dd < TO) ? drd : 32'h0;
         if (dd >= TO) m_err = 1'b1;
      end
      if (ir) begin
         xfer_q.push_back('{addr: ia, we: 1'b0, wdata: 32'h0, be: 4'hF, chk_wdata: 1'b0, delay: id, rdata: ird});
         stalls += xlen(id);
         m_instr = (id < TO) ? ird : NOP;
         if (id >= TO) m_err = 1'b1;
      end
      if (dr || ir) begin
         r = '{instr: m_instr, drdata: m_drdata, err: m_err, stalls: stalls};
         rel_q.push_back(r);
      end
      @(posedge clk); #1;
      dreq = dr; dwe = we; daddr = da; dwdata = wd; dbe = be; ireq = ir; iaddr = ia;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (!stall_o) done = 1;
      end
      if (!done) begin
         failures++;
         $display("FAIL release_timeout actual=stalled required=release");
      end
   endtask

   // Memory responder: checks each transfer's attributes and acks after its scripted delay.
   bit    rsp_active = 0;
   xfer_t cur;
   int    idx = 0;
   always @(negedge clk) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (rst) begin
         rsp_active = 0;
      end else begin
         if (!rsp_active && mem_req) begin
            if (xfer_q.size() == 0) begin
               check("unexpected_mem_req", {31'h0, mem_req}, 32'h0);
            end else begin
               cur = xfer_q.pop_front();
               idx = 0;
               rsp_active = 1;
            end
         end
         if (rsp_active) begin
            check("mem_req_held", {31'h0, mem_req}, 32'h1);
            check("mem_addr", mem_addr, cur.addr);
            check("mem_we", {31'h0, mem_we}, {31'h0, cur.we});
            check("mem_be", {28'h0, mem_be}, {28'h0, cur.be});
            if (cur.chk_wdata) check("mem_wdata", mem_wdata, cur.wdata);
            if (idx == cur.delay) begin
               mem_ack   = 1'b1;
               mem_rdata = cur.rdata;
            end
            if (idx == cur.delay || idx == TO - 1) rsp_active = 0;
            idx++;
         end
      end
   end

   // Release monitor: a stall-free cycle right after stalled ones is the RELEASE cycle.
   bit prev_stall = 0;
   int scnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
         scnt = 0;
      end else if (stall_o) begin
         prev_stall = 1;
         scnt++;
      end else begin
         if (prev_stall) begin
            if (rel_q.size() == 0) begin
               check("unexpected_release", 32'h1, 32'h0);
            end else begin
               rel_t r;
               r = rel_q.pop_front();
               check("instr_o", instr_o, r.instr);
               check("drdata_o", drdata_o, r.drdata);
               check("mem_err", {31'h0, mem_err}, {31'h0, r.err});
               check("stall_cycles", 32'(scnt), 32'(r.stalls));
               check("release_bus_idle", {mem_req, mem_we, mem_be} | 6'(mem_addr != 0), 32'h0);
            end
         end
         prev_stall = 0;
         scnt = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_instr_o", instr_o, 32'h0);
      check("rst_drdata_o", drdata_o, 32'h0);
      check("rst_mem_err", {31'h0, mem_err}, 32'h0);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      #2 rst = 1'b0;
      @(negedge clk);
      check("idle_stall", {31'h0, stall_o}, 32'h0);

      issue(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h100, 0, 32'h0, 0, 32'h0050_0093);
      issue(1, 0, 32'h2000, 32'h0, 4'hF, 1, 32'h104, 0, 32'hDEAD_BEEF, 0, 32'h0000_0013);
      issue(1, 1, 32'h2004, 32'h1234_ABCD, 4'b0011, 1, 32'h108, 3, 32'h7777_7777, 0, 32'h0010_0113);
      issue(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h10C, TO - 1, 32'h0, 0, 32'hCAFE_0001);
      issue(1, 0, 32'h2008, 32'h0, 4'hF, 0, 32'h0, TO - 1, 32'h55AA_55AA, 0, 32'h0);
      issue(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h110, TO + 3, 32'h0, TO + 3, 32'hBAD0_BAD0);
      issue(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h114, 1, 32'h0, 1, 32'h0020_0193);
      issue(1, 0, 32'h200C, 32'h0, 4'hF, 1, 32'h118, TO + 3, 32'hBAD1_BAD1, 0, 32'h0030_0213);

      for (int n = 0; n < 40; n++) begin
         issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom,
               4'($urandom), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
               pick_delay(), $urandom, pick_delay(), $urandom);
      end

      // Reset in the middle of a load that is never acked.
      @(posedge clk); #1;
      dreq = 1; dwe = 0; daddr = 32'h3000; ireq = 1; iaddr = 32'h11C;
      xfer_q.push_back('{addr: 32'h3000, we: 1'b0, wdata: dwdata, be: dbe, chk_wdata: 1'b1, delay: TO + 3, rdata: 32'h0});
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
      check("midrst_instr_o", instr_o, 32'h0);
      check("midrst_drdata_o", drdata_o, 32'h0);
      check("midrst_mem_err", {31'h0, mem_err}, 32'h0);
      xfer_q.delete();
      rel_q.delete();
      dreq = 0; ireq = 0; dwe = 0;
      m_instr = '0; m_drdata = '0; m_err = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("postrst_stall", {31'h0, stall_o}, 32'h0);
      check("postrst_mem_req", {31'h0, mem_req}, 32'h0);

      for (int n = 0; n < 10; n++) begin
         issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom,
               4'($urandom), $urandom_range(0, 1), $urandom & 32'hFFFF_FFFC,
               pick_delay(), $urandom, pick_delay(), $urandom);
      end

      repeat (3) @(negedge clk);
      check("pending_releases", 32'(rel_q.size()), 32'h0);
      check("pending_xfers", 32'(xfer_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (load/store).
- Sequences at most one data access then one fetch per pipeline advance.
- Holds the whole pipeline frozen through a single stall output until both are done.
- Sits beside the hazard unit; its stall output is OR-ed into every stage-enable alongside the hazard stalls.

Parameters:
- TIMEOUT, 64: max cycles a transfer may wait for mem_ack before abort.
- NOP_INSTR, 32'h00000013: instruction returned on an aborted fetch.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ireq  in  1  fetch needed this pipeline cycle
- iaddr  in  32  fetch address (PCF)
- dreq  in  1  MEM stage performs a load or store
- dwe  in  1  1 = store
- daddr  in  32  data address
- dwdata  in  32  store data
- dbe  in  4  store byte enables
- instr_o  out  32  fetched instruction, registered
- drdata_o  out  32  load data, registered
- stall_o  out  1  freeze all pipeline registers
- mem_req  out  1  transfer request to memory
- mem_we  out  1  write strobe
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_ack  in  1  transfer complete; mem_rdata valid this cycle
- mem_rdata  in  32  read data
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, immediate): state=IDLE, instr_o=0, drdata_o=0, timeout counter=0, mem_err=0, mem_req=0.
- States: IDLE, D_WAIT, I_WAIT, RELEASE.
- IDLE:
  - dreq=1 -> D_WAIT.
  - dreq=0 and ireq=1 -> I_WAIT.
  - neither -> stay IDLE.
  - stall_o=1 whenever dreq or ireq is set (combinational); otherwise 0.
- D_WAIT:
  - mem_req=1, mem_addr=daddr, mem_we=dwe, mem_wdata=dwdata, mem_be=dbe.
  - On mem_ack: drdata_o<=mem_rdata (stores leave drdata_o unchanged); then ireq ? I_WAIT : RELEASE.
- I_WAIT:
  - mem_req=1, mem_addr=iaddr, mem_we=0, mem_be=4'hF.
  - On mem_ack: instr_o<=mem_rdata; -> RELEASE.
- RELEASE: stall_o=0 for exactly one cycle, so the pipeline advances with instr_o and drdata_o valid; -> IDLE.
- stall_o=1 in D_WAIT and I_WAIT.
- Outside D_WAIT and I_WAIT: mem_req=0, mem_we=0, mem_be=0; mem_addr and mem_wdata are 0.
- mem_ack is ignored when not in a wait state.
- Each mem_ack completes exactly one transfer. mem_req may remain high across D_WAIT->I_WAIT; the address change marks the new transfer.
- Latency with a 1-cycle-ack memory:
  - fetch-only: 2 stall cycles (IDLE, I_WAIT), then RELEASE.
  - data+fetch: 3 stall cycles (IDLE, D_WAIT, I_WAIT), then RELEASE.
- Inputs are guaranteed stable while stall_o=1, because the pipeline is frozen.
- Timeout:
  - Counter clears on entry to a wait state and increments each wait cycle without ack.
  - When it reaches TIMEOUT-1 without ack, the transfer is aborted and mem_err<=1 (sticky until rst).
  - Aborted load: drdata_o<=0, and the state machine continues as if acked.
  - Aborted fetch: instr_o<=NOP_INSTR.
- mem_ack in the same cycle the counter hits its limit counts as success; no error.
- Reset mid-transfer: mem_req drops asynchronously and the in-flight transfer is abandoned. The memory must tolerate a dropped request.

Decomposition:
- Shared package: state enum (IDLE, D_WAIT, I_WAIT, RELEASE), the NOP_INSTR constant, and the byte-enable constant BE_WORD=4'hF.
- Sub-module mem_timeout_ctr: parameterised down-counter with clear, enable and expired outputs, counter width $clog2(TIMEOUT+1). Everything else stays in one module.

Test Plan:
- Reset with ireq=1, iaddr=0x100, memory acks after 1 cycle returning 0x00500093 -> stall_o high for 2 cycles, one mem_req to 0x100, instr_o=0x00500093 in the RELEASE cycle with stall_o=0.
- Load: dreq=1, dwe=0, daddr=0x2000, ireq=1, iaddr=0x104; mem returns 0xDEADBEEF then 0x00000013 -> D_WAIT transfer first at 0x2000, fetch second at 0x104, drdata_o=0xDEADBEEF, 3 stall cycles.
- Store: dwe=1, dbe=4'b0011, dwdata=0x1234ABCD, memory ack delayed 4 cycles -> mem_we=1 and mem_be=0011 held for all 4 wait cycles, drdata_o unchanged, fetch follows.
- Timeout: TIMEOUT=8, fetch never acked -> abort after 8 wait cycles, instr_o=0x00000013, mem_err=1, mem_err stays 1 on later good transfers.
- Ack on the final timeout cycle -> data accepted, mem_err stays 0.
- Assert rst while in D_WAIT -> mem_req=0 in the same cycle, outputs return to 0, state is IDLE on the next clk.
